lut_layer_sequencer: RTL

//  Time-multiplexes one shared truth-table RAM across NEURONS LogicNets neurons.

---
 rtl/lut_layer_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer: one shared truth-table RAM serves NEURONS
// 7-input lookups per frame. Optional perf counters are enabled by LUT_SEQ_PERF_EN.
//
// state | meaning
// IDLE  | waiting for a frame; config writes accepted
// RUN   | one neuron LUT read per cycle
// DRAIN | final LUT read result written back
// DONE  | result frame held until out_ready
module lut_layer_sequencer #(
  parameter int NEURONS  = 8,
  parameter int FANIN    = 7,
  parameter int OUT_BITS = 2,
  parameter int IN_WIDTH = 64,
  localparam int NIDX_W  = $clog2(NEURONS),
  localparam int ADDR_W  = NIDX_W + FANIN,
  localparam int IDX_W   = $clog2(IN_WIDTH),
  localparam int CFG_DW  = (OUT_BITS > IDX_W) ? OUT_BITS : IDX_W,
  localparam int OUT_W   = NEURONS * OUT_BITS,
  localparam int PW      = $clog2(FANIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  input  logic              cfg_we,
  output logic              cfg_ready,
  input  logic              cfg_sel,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CFG_DW-1:0] cfg_data
`ifdef LUT_SEQ_PERF_EN
  ,
  output logic [31:0]       frame_count,
  output logic [31:0]       busy_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic [NIDX_W-1:0]   idx_q;
  logic [NIDX_W-1:0]   tag_q;
  logic                lut_vld_q;
  logic [OUT_BITS-1:0] lut_q;
  logic [IN_WIDTH-1:0] in_q;
  logic [OUT_W-1:0]    out_data_q;
  logic                out_valid_q;
  logic [CFG_DW-1:0]   conn_q [NEURONS][FANIN];
  logic [OUT_BITS-1:0] tt_q [NEURONS*(2**FANIN)];
  logic [FANIN-1:0]    lut_addr;
  logic                accept;
  logic                cfg_acc;
  logic [NIDX_W-1:0]   cfg_nrn;
  logic [FANIN-1:0]    cfg_low;
  logic                cfg_nrn_ok;
  logic                cfg_pos_ok;

  assign cfg_nrn    = cfg_addr[ADDR_W-1 -: NIDX_W];
  assign cfg_low    = cfg_addr[FANIN-1:0];
  assign cfg_nrn_ok = 32'(cfg_nrn) < NEURONS;
  assign cfg_pos_ok = 32'(cfg_low) < FANIN;
  assign cfg_ready  = (state_q == IDLE);
  assign cfg_acc    = cfg_we && cfg_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (idx_q == NIDX_W'(NEURONS - 1)) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Connection indices past the input vector read as constant 0.
  always_comb begin
    lut_addr = '0;
    for (int p = 0; p < FANIN; p++) begin
      if (32'(conn_q[idx_q][p]) < IN_WIDTH)
        lut_addr[p] = in_q[conn_q[idx_q][p][IDX_W-1:0]];
    end
  end

  // Truth-table RAM is deliberately not reset so it survives rst.
  always_ff @(posedge clk) begin
    if (cfg_acc && !cfg_sel && cfg_nrn_ok)
      tt_q[cfg_addr] <= cfg_data[OUT_BITS-1:0];
    lut_q <= tt_q[{idx_q, lut_addr}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tag_q       <= '0;
      lut_vld_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_q        <= '0;
      for (int n = 0; n < NEURONS; n++)
        for (int p = 0; p < FANIN; p++)
          conn_q[n][p] <= CFG_DW'(p);
    end else begin
      state_q <= state_d;
      if (accept) begin
        in_q  <= in_data;
        idx_q <= '0;
      end else if (state_q == RUN) begin
        idx_q <= idx_q + 1'b1;
      end
      lut_vld_q <= (state_q == RUN);
      if (state_q == RUN) tag_q <= idx_q;
      if (lut_vld_q) out_data_q[tag_q*OUT_BITS +: OUT_BITS] <= lut_q;
      if (state_q == DRAIN)
        out_valid_q <= 1'b1;
      else if (state_q == DONE && out_ready)
        out_valid_q <= 1'b0;
      if (cfg_acc && cfg_sel && cfg_nrn_ok && cfg_pos_ok)
        conn_q[cfg_nrn][cfg_low[PW-1:0]] <= cfg_data;
    end
  end

`ifdef LUT_SEQ_PERF_EN
  logic [31:0] frame_cnt_q;
  logic [31:0] busy_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      busy_cnt_q  <= '0;
    end else begin
      if (out_valid_q && out_ready) frame_cnt_q <= frame_cnt_q + 32'd1;
      if (state_q != IDLE) busy_cnt_q <= busy_cnt_q + 32'd1;
    end
  end

  assign frame_count = frame_cnt_q;
  assign busy_cycles = busy_cnt_q;
`endif

endmodule
